// File: rtl/alu_result_bcd_display.sv
// Shows the 8-bit ALU result in decimal on three active-low 7-segment digits.
// Binary to BCD is done serially with double-dabble, one bit per clock.
module alu_result_bcd_display #(
  parameter bit AUTO_UPDATE   = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [7:0] result,
  input  logic       result_valid,
  output logic       busy,
  output logic       done,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2
);

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] LEAD_RST  = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t      state;
  logic [19:0] shift_reg;
  logic [2:0]  count;
  logic [7:0]  last;

  logic        start;
  logic [11:0] bcd_adj;
  logic [19:0] shift_next;
  logic [3:0]  hund;
  logic [3:0]  tens;
  logic [3:0]  ones;
  logic [6:0]  seg_hund;
  logic [6:0]  seg_tens;
  logic [6:0]  seg_ones;
  logic [6:0]  hex2_next;
  logic [6:0]  hex1_next;

  // In auto mode the compare is against the last converted value, so a change
  // that arrives while busy is picked up as soon as the FSM is back in IDLE.
  assign start = AUTO_UPDATE ? (result != last) : result_valid;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Add-3 correction on every BCD nibble before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dabble
      logic [3:0] nib;
      assign nib = shift_reg[8 + 4*gi +: 4];
      assign bcd_adj[4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  endgenerate

  assign shift_next = {bcd_adj[10:0], shift_reg[7:0], 1'b0};

  assign hund = shift_reg[19:16];
  assign tens = shift_reg[15:12];
  assign ones = shift_reg[11:8];

  assign seg_hund = seg7(hund);
  assign seg_tens = seg7(tens);
  assign seg_ones = seg7(ones);

  always_comb begin
    hex2_next = seg_hund;
    hex1_next = seg_tens;
    if (BLANK_LEADING && (hund == 4'd0)) begin
      hex2_next = SEG_BLANK;
      if (tens == 4'd0) begin
        hex1_next = SEG_BLANK;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
      last      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      HEX0      <= SEG_ZERO;
      HEX1      <= LEAD_RST;
      HEX2      <= LEAD_RST;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= {12'd0, result};
            last      <= result;
            count     <= 3'd0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= shift_next;
          count     <= count + 3'd1;
          if (count == 3'd7) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          HEX2  <= hex2_next;
          HEX1  <= hex1_next;
          HEX0  <= seg_ones;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_bcd_display.sv
// Bench for alu_result_bcd_display: explicit-start instances with and without
// blanking, and an auto-update instance, checked through a display scoreboard.
module tb_alu_result_bcd_display;

  logic       clk;
  logic       rst;
  logic [7:0] result;
  logic       result_valid;
  logic [7:0] result_c;

  logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [6:0] hex0_a, hex1_a, hex2_a;
  logic [6:0] hex0_b, hex1_b, hex2_b;
  logic [6:0] hex0_c, hex1_c, hex2_c;

  alu_result_bcd_display #(.AUTO_UPDATE(1'b0), .BLANK_LEADING(1'b1)) dut_a (
    .CLOCK_50(clk), .rst(rst), .result(result), .result_valid(result_valid),
    .busy(busy_a), .done(done_a), .HEX0(hex0_a), .HEX1(hex1_a), .HEX2(hex2_a)
  );

  alu_result_bcd_display #(.AUTO_UPDATE(1'b0), .BLANK_LEADING(1'b0)) dut_b (
    .CLOCK_50(clk), .rst(rst), .result(result), .result_valid(result_valid),
    .busy(busy_b), .done(done_b), .HEX0(hex0_b), .HEX1(hex1_b), .HEX2(hex2_b)
  );

  alu_result_bcd_display #(.AUTO_UPDATE(1'b1), .BLANK_LEADING(1'b1)) dut_c (
    .CLOCK_50(clk), .rst(rst), .result(result_c), .result_valid(result_valid),
    .busy(busy_c), .done(done_c), .HEX0(hex0_c), .HEX1(hex1_c), .HEX2(hex2_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] h2;
    logic [6:0] h1;
    logic [6:0] h0;
  } disp_t;

  typedef struct {
    logic [7:0] value;
    disp_t      blanked;
    disp_t      full;
  } vec_t;

  disp_t q_a[$];
  disp_t q_b[$];
  disp_t q_c[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_a_cnt = 0;
  int done_b_cnt = 0;
  int done_c_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops the expected display for that instance.
  always @(negedge clk) begin
    if (done_a) begin
      done_a_cnt++;
      if (q_a.size() == 0) begin
        check("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        disp_t e;
        e = q_a.pop_front();
        $display("a: done HEX2=%b HEX1=%b HEX0=%b", hex2_a, hex1_a, hex0_a);
        check("a_display", {11'd0, hex2_a, hex1_a, hex0_a}, {11'd0, e});
      end
    end
    if (done_b) begin
      done_b_cnt++;
      if (q_b.size() == 0) begin
        check("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        disp_t e;
        e = q_b.pop_front();
        $display("b: done HEX2=%b HEX1=%b HEX0=%b", hex2_b, hex1_b, hex0_b);
        check("b_display", {11'd0, hex2_b, hex1_b, hex0_b}, {11'd0, e});
      end
    end
    if (done_c) begin
      done_c_cnt++;
      if (q_c.size() == 0) begin
        check("c_unexpected_done", 32'd1, 32'd0);
      end else begin
        disp_t e;
        e = q_c.pop_front();
        $display("c: done HEX2=%b HEX1=%b HEX0=%b", hex2_c, hex1_c, hex0_c);
        check("c_display", {11'd0, hex2_c, hex1_c, hex0_c}, {11'd0, e});
      end
    end
  end

  // Start a conversion on dut_a/dut_b and verify the busy/done timeline.
  task automatic run_conv(input vec_t v);
    logic ok_busy;
    @(negedge clk);
    result       = v.value;
    result_valid = 1'b1;
    q_a.push_back(v.blanked);
    q_b.push_back(v.full);
    $display("start value=%0d", v.value);
    @(negedge clk);
    result_valid = 1'b0;
    check("busy_after_start", {31'd0, busy_a}, 32'd1);
    ok_busy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (busy_a !== 1'b1 || done_a !== 1'b0 || busy_b !== 1'b1) ok_busy = 1'b0;
    end
    check("busy_window", {31'd0, ok_busy}, 32'd1);
    @(negedge clk);
    check("done_at_n9", {30'd0, done_a, busy_a}, {30'd0, 2'b10});
    @(negedge clk);
    check("done_one_cycle", {31'd0, done_a}, 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vecs[0] = '{8'd255, '{7'b0100100, 7'b0010010, 7'b0010010}, '{7'b0100100, 7'b0010010, 7'b0010010}};
    vecs[1] = '{8'd7,   '{7'b1111111, 7'b1111111, 7'b1111000}, '{7'b1000000, 7'b1000000, 7'b1111000}};
    vecs[2] = '{8'd105, '{7'b1111001, 7'b1000000, 7'b0010010}, '{7'b1111001, 7'b1000000, 7'b0010010}};
    vecs[3] = '{8'd0,   '{7'b1111111, 7'b1111111, 7'b1000000}, '{7'b1000000, 7'b1000000, 7'b1000000}};
    vecs[4] = '{8'd200, '{7'b0100100, 7'b1000000, 7'b1000000}, '{7'b0100100, 7'b1000000, 7'b1000000}};
    vecs[5] = '{8'd42,  '{7'b1111111, 7'b0011001, 7'b0100100}, '{7'b1000000, 7'b0011001, 7'b0100100}};
    vecs[6] = '{8'd99,  '{7'b1111111, 7'b0010000, 7'b0010000}, '{7'b1000000, 7'b0010000, 7'b0010000}};
    vecs[7] = '{8'd100, '{7'b1111001, 7'b1000000, 7'b1000000}, '{7'b1111001, 7'b1000000, 7'b1000000}};
    vecs[8] = '{8'd10,  '{7'b1111111, 7'b1111001, 7'b1000000}, '{7'b1000000, 7'b1111001, 7'b1000000}};

    rst          = 1'b1;
    result       = 8'd0;
    result_valid = 1'b0;
    result_c     = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_a_display", {11'd0, hex2_a, hex1_a, hex0_a}, {11'd0, 7'b1111111, 7'b1111111, 7'b1000000});
    check("rst_b_display", {11'd0, hex2_b, hex1_b, hex0_b}, {11'd0, 7'b1000000, 7'b1000000, 7'b1000000});
    check("rst_flags", {26'd0, busy_a, done_a, busy_b, done_b, busy_c, done_c}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i]);
    end

    // Second request while busy is dropped; bus change mid-conversion ignored.
    base = done_a_cnt;
    @(negedge clk);
    result       = 8'd200;
    result_valid = 1'b1;
    q_a.push_back(vecs[4].blanked);
    q_b.push_back(vecs[4].full);
    $display("start value=200, then 99 while busy");
    @(negedge clk);
    result_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    result       = 8'd99;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    repeat (14) @(negedge clk);
    check("dropped_one_done", done_a_cnt - base, 32'd1);
    check("dropped_display", {11'd0, hex2_a, hex1_a, hex0_a}, {11'd0, vecs[4].blanked});

    // Reset in the middle of a conversion of 255.
    base = done_a_cnt;
    @(negedge clk);
    result       = 8'd255;
    result_valid = 1'b1;
    $display("start value=255, reset at N+4");
    @(negedge clk);
    result_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_a_display", {11'd0, hex2_a, hex1_a, hex0_a}, {11'd0, 7'b1111111, 7'b1111111, 7'b1000000});
    check("abort_b_display", {11'd0, hex2_b, hex1_b, hex0_b}, {11'd0, 7'b1000000, 7'b1000000, 7'b1000000});
    check("abort_flags", {30'd0, busy_a, done_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_done", done_a_cnt - base, 32'd0);
    run_conv(vecs[5]);

    // Auto-update instance: result_c held at 0 so far, valid pulses ignored.
    check("auto_idle_no_done", done_c_cnt, 32'd0);
    check("auto_idle_display", {11'd0, hex2_c, hex1_c, hex0_c}, {11'd0, 7'b1111111, 7'b1111111, 7'b1000000});
    @(negedge clk);
    result_c = 8'd9;
    q_c.push_back('{7'b1111111, 7'b1111111, 7'b0010000});
    $display("auto: result_c=9");
    @(negedge clk);
    check("auto_busy", {31'd0, busy_c}, 32'd1);
    repeat (2) @(negedge clk);
    result_c = 8'd13;
    q_c.push_back('{7'b1111111, 7'b1111001, 7'b0110000});
    $display("auto: result_c=13 while busy");
    repeat (6) @(negedge clk);
    check("auto_done_n8", {31'd0, done_c}, 32'd0);
    @(negedge clk);
    check("auto_done_n9", {31'd0, done_c}, 32'd1);
    @(negedge clk);
    check("auto_restart_busy", {30'd0, busy_c, done_c}, {30'd0, 2'b10});
    repeat (8) @(negedge clk);
    check("auto_done_n18", {31'd0, done_c}, 32'd0);
    @(negedge clk);
    check("auto_done_n19", {31'd0, done_c}, 32'd1);
    repeat (15) @(negedge clk);
    check("auto_total_done", done_c_cnt, 32'd2);

    check("q_a_empty", q_a.size(), 32'd0);
    check("q_b_empty", q_b.size(), 32'd0);
    check("q_c_empty", q_c.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
